alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Instruction-issue and writeback controller for the 16-bit ALU. It is the driving end of the ALU functCode/op1/op2 interface and the consuming end of its result/remainder/overflow interface. It accepts 16-bit three-register instructions over a valid/ready handshake and reads operands from an internal 16x16 register file. It drives the ALU, waits a fixed ALU latency, then writes result and remainder back and tracks a sticky overflow flag.

Parameters:
- ALU_LAT, 1: clock cycles from operands valid to alu_result valid. Must be >= 1.
- W, 16: datapath width.
- NOP_CODE, 4'b1111: function code that skips the ALU and writeback.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  16  [15:12] funct, [11:8] rd, [7:4] rs1, [3:0] rs2.
- ld_en  in  1  preload register write; honoured only in IDLE.
- ld_addr  in  4  preload target register.
- ld_data  in  W  preload data.
- alu_funct  out  4  to ALU functCode.
- alu_op1  out  W  to ALU op1, signed.
- alu_op2  out  W  to ALU op2, signed.
- alu_start  out  1  one-cycle pulse in the first EXEC cycle.
- alu_result  in  W  from ALU.
- alu_remainder  in  W  from ALU; remainder for div, high word for mult.
- alu_ovf  in  1  from ALU overflow.
- ovf_clr  in  1  clear sticky overflow.
- ovf_sticky  out  1  sticky overflow flag.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse in the final writeback cycle.
- dbg_addr  in  4  debug register read address.
- dbg_data  out  W  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and all 16 registers clear to 0.
  - alu_funct, alu_op1, alu_op2, alu_start, done and ovf_sticky all go to 0.
  - Takes effect immediately, including mid-EXEC or mid-WB; no pending writeback survives.
- States: IDLE -> EXEC -> WB -> (WB2) -> IDLE.
- IDLE:
  - instr_ready=1.
  - Handshake fires when instr_valid & instr_ready at a rising edge (cycle T).
  - At that edge: latch funct and rd; register alu_funct=funct, alu_op1=R[rs1], alu_op2=R[rs2]; next state is EXEC.
  - If funct==NOP_CODE: next state is IDLE instead, done pulses in T+1, and no ALU or register activity occurs.
  - ld_en writes R[ld_addr]=ld_data in IDLE. If a handshake fires in the same cycle, operands read the pre-write values.
- EXEC:
  - Lasts exactly ALU_LAT cycles (T+1 .. T+ALU_LAT).
  - alu_start=1 only in T+1.
  - Operands and funct are held stable from EXEC through WB/WB2.
- WB (cycle T+ALU_LAT+1):
  - alu_result is valid; written to R[rd] at the end of the cycle.
  - If alu_ovf=1, ovf_sticky sets.
  - For funct 4'b0100 (mult) or 4'b0101 (div): next state is WB2. Otherwise done=1 this cycle and next state is IDLE.
- WB2 (cycle T+ALU_LAT+2):
  - alu_remainder is written to R[15] and done=1.
  - If rd==15, the WB2 write overwrites the WB write, so R15 ends up holding the remainder.
- instr_ready is 0 in every state except IDLE.
  - Exactly one instruction is outstanding, so there are no data hazards.
  - A back-to-back instruction is accepted at the earliest in the cycle after done.
- ovf_clr clears ovf_sticky. If a set and ovf_clr occur in the same cycle, the set wins.
- No arithmetic is done here. Values pass through unmodified, signed, W bits wide.
- Unknown funct codes (other than NOP) are forwarded to the ALU unchanged and take the single-writeback path.

Decomposition:
- Shared package alu_pkg:
  - Function-code constants: FN_ADD=4'b0000, FN_MULT=4'b0100, FN_DIV=4'b0101, FN_NOP=4'b1111.
  - State encoding: IDLE, EXEC, WB, WB2.
  - Instruction field bit positions.
- One natural sub-module: alu_regfile.
  - 16xW storage, async-reset to 0.
  - Two combinational read ports plus a dbg read port.
  - One write port, muxed between preload and writeback.

Test Plan:
1. Hold rst=0 for 2 cycles, then release -> instr_ready=1, busy=0, dbg_data=0 for all 16 addresses, ovf_sticky=0.
2. Preload R1=16'h1111, R2=16'h8888; instr=16'h0312 accepted at T (ALU_LAT=1) -> T+1: alu_funct=0000, op1=1111, op2=8888, alu_start=1; T+2: done=1; then R3=16'h9999 and ovf_sticky=0.
3. Preload R1=R2=16'h0001; instr=16'h4412 -> WB writes R4=16'h0001; WB2 writes R15=alu_remainder (16'h0000); done=1 only at T+3.
4. Preload R1=16'h7FFF, R2=16'h0001; add into R5 with ALU asserting alu_ovf -> ovf_sticky=1. Assert ovf_clr in that same WB cycle -> stays 1. Assert ovf_clr the next cycle -> 0.
5. Hold instr_valid=1 continuously with two instructions -> instr_ready=0 during EXEC/WB; second handshake occurs exactly in the cycle after done; NOP (16'hF000) -> done at T+1 and no register changes.
6. Assert rst=0 asynchronously mid-EXEC of an add into R6 -> all outputs are 0 immediately; after release R6=0, and no done or writeback occurs.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU issue/writeback sequencer
//
// Purpose: function codes, FSM state encoding, instruction field layout and a
// small decode helper used by alu_sequencer and its testbench.
// Ports: none (package).
package alu_pkg;

    // ALU function codes that the sequencer needs to recognise.
    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_MULT = 4'b0100;
    localparam logic [3:0] FN_DIV  = 4'b0101;
    localparam logic [3:0] FN_NOP  = 4'b1111;

    // Sequencer FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;
    localparam logic [1:0] ST_WB2  = 2'd3;

    // Instruction layout: [15:12] funct, [11:8] rd, [7:4] rs1, [3:0] rs2.
    typedef struct packed {
        logic [3:0] funct;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } instr_t;

    // mult and div produce a second word (high product / remainder) for R15.
    function automatic logic has_second_wb(input logic [3:0] funct);
        return (funct == FN_MULT) || (funct == FN_DIV);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 16xW register file with two operand read ports and a debug read port
//
// Purpose: operand storage for the sequencer; all reads are combinational so
// a same-cycle write is not visible until the following cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears all entries)
//   we, waddr, wdata    single write port
//   raddr1/rdata1       operand read port 1
//   raddr2/rdata2       operand read port 2
//   dbg_addr/dbg_data   debug read port
module alu_regfile #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [3:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [3:0]   raddr1,
    output logic [W-1:0] rdata1,
    input  logic [3:0]   raddr2,
    output logic [W-1:0] rdata2,
    input  logic [3:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);

    logic [W-1:0] mem_q [16];
    logic [W-1:0] mem_d [16];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata1   = mem_q[raddr1];
    assign rdata2   = mem_q[raddr2];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - instruction issue and writeback controller for the 16-bit ALU
//
// Purpose: accepts one three-register instruction at a time, drives the ALU
// with registered operands, waits ALU_LAT cycles, writes the result to rd and,
// for mult/div, the second word to R15. Tracks a sticky overflow flag.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   instr_valid/instr_ready/instr  instruction handshake
//   ld_en/ld_addr/ld_data          register preload (IDLE only)
//   alu_funct/alu_op1/alu_op2      ALU drive, alu_start pulses in first EXEC cycle
//   alu_result/alu_remainder/alu_ovf  ALU outputs
//   ovf_clr/ovf_sticky             sticky overflow
//   busy, done                     status, done pulses in final writeback cycle
//   dbg_addr/dbg_data              combinational register read
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int         ALU_LAT  = 1,
    parameter int         W        = 16,
    parameter logic [3:0] NOP_CODE = FN_NOP
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [15:0]  instr,
    input  logic         ld_en,
    input  logic [3:0]   ld_addr,
    input  logic [W-1:0] ld_data,
    output logic [3:0]   alu_funct,
    output logic [W-1:0] alu_op1,
    output logic [W-1:0] alu_op2,
    output logic         alu_start,
    input  logic [W-1:0] alu_result,
    input  logic [W-1:0] alu_remainder,
    input  logic         alu_ovf,
    input  logic         ovf_clr,
    output logic         ovf_sticky,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    logic [1:0]       state_q,  state_d;
    logic [3:0]       funct_q,  funct_d;
    logic [3:0]       rd_q,     rd_d;
    logic [W-1:0]     op1_q,    op1_d;
    logic [W-1:0]     op2_q,    op2_d;
    logic             start_q,  start_d;
    logic             done_q,   done_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    instr_t       dec;
    logic [W-1:0] rdata1;
    logic [W-1:0] rdata2;
    logic         rf_we;
    logic [3:0]   rf_waddr;
    logic [W-1:0] rf_wdata;
    logic         exec_last;
    logic         two_wb;

    assign dec       = instr;
    assign exec_last = (cnt_q == CNT_W'(ALU_LAT - 1));
    assign two_wb    = has_second_wb(funct_q);

    alu_regfile #(.W(W)) u_regfile (
        .clk      (clk),
        .rst_n    (rst),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr1   (dec.rs1),
        .rdata1   (rdata1),
        .raddr2   (dec.rs2),
        .rdata2   (rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Next-state logic. done is registered so that it can pulse in the cycle
    // after a NOP handshake while the FSM stays in IDLE.
    always_comb begin
        state_d = state_q;
        funct_d = funct_q;
        rd_d    = rd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (dec.funct == NOP_CODE) begin
                        done_d = 1'b1;
                    end else begin
                        funct_d = dec.funct;
                        rd_d    = dec.rd;
                        op1_d   = rdata1;
                        op2_d   = rdata2;
                        cnt_d   = '0;
                        start_d = 1'b1;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (exec_last) begin
                    state_d = ST_WB;
                    done_d  = !two_wb;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                if (two_wb) begin
                    state_d = ST_WB2;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB2: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Overflow only counts in the cycle alu_result is valid; a set beats a clear.
    always_comb begin
        sticky_d = ((state_q == ST_WB) && alu_ovf) || (sticky_q && !ovf_clr);
    end

    // Register write port: preload in IDLE, result in WB, second word in WB2.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = ld_addr;
        rf_wdata = ld_data;
        case (state_q)
            ST_IDLE: rf_we = ld_en;
            ST_WB: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = alu_result;
            end
            ST_WB2: begin
                rf_we    = 1'b1;
                rf_waddr = 4'hF;
                rf_wdata = alu_remainder;
            end
            default: rf_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            funct_q  <= '0;
            rd_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct_q  <= funct_d;
            rd_q     <= rd_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            done_q   <= done_d;
            sticky_q <= sticky_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign alu_funct   = funct_q;
    assign alu_op1     = op1_q;
    assign alu_op2     = op2_q;
    assign alu_start   = start_q;
    assign done        = done_q;
    assign ovf_sticky  = sticky_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [3:0]  alu_funct;
    logic [15:0] alu_op1;
    logic [15:0] alu_op2;
    logic        alu_start;
    logic [15:0] alu_result;
    logic [15:0] alu_remainder;
    logic        alu_ovf;
    logic        ovf_clr = 1'b0;
    logic        ovf_sticky;
    logic        busy;
    logic        done;
    logic [3:0]  dbg_addr = '0;
    logic [15:0] dbg_data;
    logic        ovf_force = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.ALU_LAT(LAT), .W(16), .NOP_CODE(FN_NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .ld_en         (ld_en),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .alu_funct     (alu_funct),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_start     (alu_start),
        .alu_result    (alu_result),
        .alu_remainder (alu_remainder),
        .alu_ovf       (alu_ovf),
        .ovf_clr       (ovf_clr),
        .ovf_sticky    (ovf_sticky),
        .busy          (busy),
        .done          (done),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    // Reference ALU: returns {second word, result}.
    function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        logic [15:0] res;
        logic [15:0] rem;
        res = a ^ b;
        rem = '0;
        case (f)
            FN_ADD:  res = a + b;
            4'b0001: res = a - b;
            FN_MULT: begin
                p   = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
                res = p[15:0];
                rem = p[31:16];
            end
            FN_DIV: begin
                if (b != 16'h0) begin
                    res = 16'($signed(a) / $signed(b));
                    rem = 16'($signed(a) % $signed(b));
                end
            end
            default: res = a ^ b;
        endcase
        return {rem, res};
    endfunction

    // ALU stand-in: the sequencer holds operands stable, so a combinational
    // answer is valid by the writeback cycle for any latency.
    assign {alu_remainder, alu_result} = alu_ref(alu_funct, alu_op1, alu_op2);
    assign alu_ovf = ovf_force;

    // ---------------- behavioural model ----------------
    // Period p is the clock period that follows rising edge p.
    int          per = 0;
    int          busy_last = -1;
    int          done_p = -1;
    int          start_p = -1;
    int          wb_p = -1;
    int          wb2_p = -1;
    int          last_hs = -1;
    logic [15:0] exp_r [16];
    logic [3:0]  m_funct = '0;
    logic [3:0]  m_rd = '0;
    logic [15:0] m_op1 = '0;
    logic [15:0] m_op2 = '0;
    logic        m_sticky = 1'b0;
    logic        mv_rdy, mv_set, mv_hs;
    logic [15:0] mv_res, mv_rem, mv_a, mv_b;
    logic [3:0]  mv_fn, mv_rd;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) exp_r[i] = '0;
            busy_last = -1; done_p = -1; start_p = -1; wb_p = -1; wb2_p = -1;
            m_funct = '0; m_rd = '0; m_op1 = '0; m_op2 = '0; m_sticky = 1'b0;
        end else begin
            mv_rdy = (per > busy_last);
            mv_set = 1'b0;
            {mv_rem, mv_res} = alu_ref(m_funct, m_op1, m_op2);
            if (wb_p == per) begin
                exp_r[m_rd] = mv_res;
                mv_set = alu_ovf;
            end
            if (wb2_p == per) exp_r[15] = mv_rem;
            if (mv_set) m_sticky = 1'b1;
            else if (ovf_clr) m_sticky = 1'b0;
            mv_hs = mv_rdy && instr_valid;
            mv_fn = instr[15:12];
            mv_rd = instr[11:8];
            mv_a  = exp_r[instr[7:4]];
            mv_b  = exp_r[instr[3:0]];
            if (mv_rdy && ld_en) exp_r[ld_addr] = ld_data;
            per++;
            if (mv_hs) begin
                last_hs = per;
                if (mv_fn == FN_NOP) begin
                    done_p = per;
                end else begin
                    m_funct = mv_fn; m_rd = mv_rd; m_op1 = mv_a; m_op2 = mv_b;
                    start_p = per;
                    wb_p = per + LAT;
                    if (mv_fn == FN_MULT || mv_fn == FN_DIV) begin
                        wb2_p  = wb_p + 1;
                        done_p = wb2_p;
                    end else begin
                        done_p = wb_p;
                    end
                    busy_last = done_p;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("instr_ready", 32'(instr_ready), 32'(per > busy_last));
            chk("busy",        32'(busy),        32'(per <= busy_last));
            chk("done",        32'(done),        32'(per == done_p));
            chk("alu_start",   32'(alu_start),   32'(per == start_p));
            chk("alu_funct",   32'(alu_funct),   32'(m_funct));
            chk("alu_op1",     32'(alu_op1),     32'(m_op1));
            chk("alu_op2",     32'(alu_op2),     32'(m_op2));
            chk("ovf_sticky",  32'(ovf_sticky),  32'(m_sticky));
            chk("dbg_data",    32'(dbg_data),    32'(exp_r[dbg_addr]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_period(input int p);
        int guard = 0;
        while (per < p && guard < 200) begin
            tick();
            guard++;
        end
        chk("reach_period", 32'(per), 32'(p));
    endtask

    task automatic ld(input logic [3:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic wait_hs(output int e);
        int guard = 0;
        do begin
            tick();
            guard++;
        end while (last_hs != per && guard < 50);
        chk("handshake_seen", 32'(last_hs == per), 32'd1);
        e = per;
    endtask

    task automatic issue(input logic [15:0] ins, output int e);
        instr = ins;
        instr_valid = 1'b1;
        wait_hs(e);
        instr_valid = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a, input logic [15:0] exp, input string name);
        dbg_addr = a;
        @(negedge clk);
        #1;
        chk(name, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, ea, eb, en;

        // 1: reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("reset_ready", 32'(instr_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sticky", 32'(ovf_sticky), 32'd0);
        for (int a = 0; a < 16; a++) peek(4'(a), 16'h0000, "reset_reg");

        // 2: add R3 = R1 + R2
        tick();
        ld(4'd1, 16'h1111);
        ld(4'd2, 16'h8888);
        issue(16'h0312, e);
        chk("add_funct", 32'(alu_funct), 32'h0);
        chk("add_op1", 32'(alu_op1), 32'h1111);
        chk("add_op2", 32'(alu_op2), 32'h8888);
        chk("add_start", 32'(alu_start), 32'd1);
        chk("add_done_early", 32'(done), 32'd0);
        goto_period(e + 1);
        chk("add_done", 32'(done), 32'd1);
        chk("add_start_off", 32'(alu_start), 32'd0);
        goto_period(e + 2);
        chk("add_done_off", 32'(done), 32'd0);
        peek(4'd3, 16'h9999, "add_r3");
        chk("add_sticky", 32'(ovf_sticky), 32'd0);

        // 3: mult R4 = R1 * R2, second word to R15
        tick();
        ld(4'd1, 16'h0001);
        ld(4'd2, 16'h0001);
        ld(4'd15, 16'hABCD);
        issue(16'h4412, e);
        goto_period(e + 1);
        chk("mult_no_done_wb", 32'(done), 32'd0);
        goto_period(e + 2);
        chk("mult_done_wb2", 32'(done), 32'd1);
        goto_period(e + 3);
        peek(4'd4, 16'h0001, "mult_r4");
        peek(4'd15, 16'h0000, "mult_r15");

        // 3b: div with rd=15: remainder overwrites quotient
        tick();
        ld(4'd1, 16'h0007);
        ld(4'd2, 16'h0002);
        issue(16'h5F12, e);
        goto_period(e + 3);
        peek(4'd15, 16'h0001, "div_rd15_rem");

        // 4: overflow sticky, same-cycle clear loses, next-cycle clear wins
        tick();
        ld(4'd1, 16'h7FFF);
        ld(4'd2, 16'h0001);
        ovf_force = 1'b1;
        issue(16'h0512, e);
        goto_period(e + 1);
        ovf_clr = 1'b1;
        goto_period(e + 2);
        chk("ovf_set_wins", 32'(ovf_sticky), 32'd1);
        ovf_force = 1'b0;
        goto_period(e + 3);
        chk("ovf_cleared", 32'(ovf_sticky), 32'd0);
        ovf_clr = 1'b0;
        peek(4'd5, 16'h8000, "ovf_r5");

        // 5: instr_valid held high, back-to-back, dependent, then NOP
        tick();
        instr = 16'h0712;
        instr_valid = 1'b1;
        wait_hs(ea);
        instr = 16'h0871;
        wait_hs(eb);
        chk("b2b_gap", 32'(eb - ea), 32'(LAT + 2));
        instr = 16'hF312;
        wait_hs(en);
        instr_valid = 1'b0;
        chk("nop_gap", 32'(en - eb), 32'(LAT + 2));
        chk("nop_done", 32'(done), 32'd1);
        chk("nop_ready", 32'(instr_ready), 32'd1);
        goto_period(en + 1);
        chk("nop_done_off", 32'(done), 32'd0);
        peek(4'd7, 16'h8000, "b2b_r7");
        peek(4'd8, 16'hFFFF, "b2b_r8");
        peek(4'd3, 16'h9999, "nop_r3_kept");

        // 6: asynchronous reset mid-EXEC
        tick();
        ld(4'd1, 16'h0002);
        ld(4'd2, 16'h0003);
        issue(16'h0612, e);
        #2 rst = 1'b0;
        #1;
        chk("arst_funct", 32'(alu_funct), 32'h0);
        chk("arst_op1", 32'(alu_op1), 32'h0);
        chk("arst_op2", 32'(alu_op2), 32'h0);
        chk("arst_start", 32'(alu_start), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_sticky", 32'(ovf_sticky), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        peek(4'd6, 16'h0000, "arst_r6");
        peek(4'd1, 16'h0000, "arst_r1");
        repeat (3) tick();

        // recovery after reset
        ld(4'd1, 16'h0005);
        ld(4'd2, 16'h0006);
        issue(16'h0912, e);
        goto_period(e + 2);
        peek(4'd9, 16'h000B, "recover_r9");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
